systolic_array_load_sequencer: RTL and testbench
================================================

SYSTOLIC_ARRAY_LOAD_SEQUENCER -- requirements
Module: systolic_array_load_sequencer

Interface
REQ-001 SHALL have parameter ARRAY_DIM, default 4, meaning the systolic array is ARRAY_DIM x ARRAY_DIM.
REQ-002 SHALL define derived RW = $clog2(ARRAY_DIM), COMPUTE_LEN = 3*ARRAY_DIM-2 and CW = $clog2(COMPUTE_LEN)+1 as the row index width, compute phase length and compute counter width.
REQ-003 SHALL have ports, one per line:
- CLK  in  1  sole clock; all state changes on rising edge.
- RST  in  1  synchronous, active-high reset.
- start  in  1  request a new tile operation; accepted only when ready=1.
- ready  out  1  sequencer in IDLE and able to accept start.
- load_valid  in  1  memory presents one row beat (weights or inputs).
- load_ready  out  1  sequencer accepts the row beat this cycle.
- weight_load  out  1  accepted beat is a weight row.
- input_load  out  1  accepted beat is an input row.
- load_row  out  RW  row index of the accepted beat.
- mac_start  out  1  one-cycle pulse at compute start.
- mac_count  out  1  high for every compute cycle.
- fifo_shift  out  ARRAY_DIM  per-row input FIFO shift enable, skewed.
- out_valid  out  1  a result row is presented.
- row_out  out  RW  result row index.
- iteration  out  RW+1  tile id of the current/most recent operation.
- done  out  1  one-cycle pulse on last result row.

Function
REQ-004 SHALL implement states IDLE, LOAD_W, LOAD_I, COMPUTE, DRAIN with a row counter (RW+1 bits) and a compute counter (CW bits).
REQ-005 IDLE: ready=1, load_ready=0; start=1 -> LOAD_W, row counter=0, iteration incremented (wraps at 2^(RW+1)).
REQ-006 start while ready=0 SHALL be ignored, with no effect on state or iteration.
REQ-007 LOAD_W: load_ready=1; each cycle with load_valid=1 SHALL assert weight_load=1 and load_row=row counter combinationally, then increment the row counter.
REQ-008 The ARRAY_DIM-th accepted weight beat SHALL move to LOAD_I with the row counter cleared.
REQ-009 LOAD_I: same handshake as LOAD_W but asserting input_load; the ARRAY_DIM-th beat SHALL move to COMPUTE with the compute counter = 0.
REQ-010 weight_load, input_load SHALL be 0 in any cycle without an accepted beat; load_row SHALL be 0 when no beat is accepted.
REQ-011 load_valid with load_ready=0 SHALL be ignored (no beat consumed).
REQ-012 COMPUTE SHALL last exactly COMPUTE_LEN cycles: mac_count=1 in each, mac_start=1 only when the compute counter = 0.
REQ-013 In COMPUTE, fifo_shift[r] SHALL be 1 iff r <= compute counter < r+ARRAY_DIM; fifo_shift SHALL be all-zero outside COMPUTE.
REQ-014 After the cycle with compute counter = COMPUTE_LEN-1, SHALL enter DRAIN with the row counter = 0.
REQ-015 DRAIN: out_valid=1, row_out=row counter for ARRAY_DIM consecutive cycles (0..ARRAY_DIM-1).
REQ-016 On the DRAIN cycle with row_out=ARRAY_DIM-1, done SHALL be 1 and the next state SHALL be IDLE.
REQ-017 start asserted in the same cycle as done SHALL be ignored, because ready=0 that cycle.
REQ-018 Total latency from the last accepted input beat to done SHALL be COMPUTE_LEN+ARRAY_DIM cycles.
REQ-019 Outputs not explicitly asserted in a state SHALL be 0; all control outputs SHALL be decoded from registered state only, except load-side outputs, which also depend on load_valid.

Reset
REQ-020 RST=1 at a clock edge SHALL force IDLE, clear both counters, set iteration=0 and deassert every output except ready (ready=1 in the following cycle).
REQ-021 Reset asserted in any state, including mid-LOAD or mid-COMPUTE, SHALL abandon the tile with no done pulse; partially loaded rows are discarded.
REQ-022 RST SHALL take priority over start and load_valid in the same cycle.

Verification (ARRAY_DIM=4, COMPUTE_LEN=10)
REQ-023 Nominal run: start, then 8 back-to-back load_valid beats.
- Response: weight_load with rows 0..3, then input_load with rows 0..3.
- Then mac_start 1 cycle and mac_count 10 cycles.
- fifo_shift[3] high in compute cycles 3..6.
- Then out_valid for rows 0..3 and done on row 3, 14 cycles after the last input beat; iteration=1.
REQ-024 Gapped loads: load_valid toggling 1/0 during LOAD_W/LOAD_I -> only cycles with load_valid=1 counted; rows stay contiguous 0..3; no extra beats accepted.
REQ-025 Busy start: start pulsed during LOAD_I, COMPUTE and the done cycle -> ignored; iteration unchanged; ready rises the cycle after done.
REQ-026 Mid-op reset: RST at compute cycle 5 -> next cycle IDLE, fifo_shift=0, mac_count=0, iteration=0, no done; a new start then runs the nominal sequence exactly.
REQ-027 Wrap: 8 consecutive full operations -> iteration sequence 1..7,0.
REQ-028 Idle noise: load_valid=1 held in IDLE with no start -> load_ready=0, no weight_load/input_load pulses, state remains IDLE.

Source files
------------

// File: rtl/systolic_array_load_sequencer.sv
// Load/compute/drain sequencer for an ARRAY_DIM x ARRAY_DIM systolic array.
// Loads weight rows, then input rows, then runs the skewed MAC phase and drains the result rows.
module systolic_array_load_sequencer #(
  parameter  int ARRAY_DIM   = 4,
  localparam int RW          = $clog2(ARRAY_DIM),
  localparam int COMPUTE_LEN = 3*ARRAY_DIM-2,
  localparam int CW          = $clog2(COMPUTE_LEN)+1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  output logic                 ready,
  input  logic                 load_valid,
  output logic                 load_ready,
  output logic                 weight_load,
  output logic                 input_load,
  output logic [RW-1:0]        load_row,
  output logic                 mac_start,
  output logic                 mac_count,
  output logic [ARRAY_DIM-1:0] fifo_shift,
  output logic                 out_valid,
  output logic [RW-1:0]        row_out,
  output logic [RW:0]          iteration,
  output logic                 done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_W  = 3'd1;
  localparam logic [2:0] S_LOAD_I  = 3'd2;
  localparam logic [2:0] S_COMPUTE = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;

  localparam logic [RW:0]   ROW_LAST  = (RW+1)'(ARRAY_DIM - 1);
  localparam logic [CW-1:0] COMP_LAST = CW'(COMPUTE_LEN - 1);

  // Registered FSM state; kept as a named signal so checkers can bind to it.
  logic [2:0]    state;
  logic [RW:0]   row_cnt;
  logic [CW-1:0] comp_cnt;
  logic          beat;

  // A row beat transfers in a cycle where load_valid and load_ready are both 1;
  // load_valid while load_ready is 0 is simply not consumed.
  assign beat = load_valid && load_ready;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      row_cnt   <= '0;
      comp_cnt  <= '0;
      iteration <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_LOAD_W;
            row_cnt   <= '0;
            iteration <= iteration + 1'b1;
          end
        end
        S_LOAD_W: begin
          if (load_valid) begin
            if (row_cnt == ROW_LAST) begin
              state   <= S_LOAD_I;
              row_cnt <= '0;
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end
        end
        S_LOAD_I: begin
          if (load_valid) begin
            if (row_cnt == ROW_LAST) begin
              state    <= S_COMPUTE;
              row_cnt  <= '0;
              comp_cnt <= '0;
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end
        end
        S_COMPUTE: begin
          if (comp_cnt == COMP_LAST) begin
            state   <= S_DRAIN;
            row_cnt <= '0;
          end else begin
            comp_cnt <= comp_cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (row_cnt == ROW_LAST) begin
            state   <= S_IDLE;
            row_cnt <= '0;
          end else begin
            row_cnt <= row_cnt + 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          row_cnt <= '0;
        end
      endcase
    end
  end

  always_comb begin
    ready       = (state == S_IDLE);
    load_ready  = (state == S_LOAD_W) || (state == S_LOAD_I);
    weight_load = (state == S_LOAD_W) && load_valid;
    input_load  = (state == S_LOAD_I) && load_valid;
    load_row    = beat ? row_cnt[RW-1:0] : '0;
    mac_count   = (state == S_COMPUTE);
    mac_start   = (state == S_COMPUTE) && (comp_cnt == '0);
    out_valid   = (state == S_DRAIN);
    row_out     = (state == S_DRAIN) ? row_cnt[RW-1:0] : '0;
    done        = (state == S_DRAIN) && (row_cnt == ROW_LAST);
  end

  // Row r's input FIFO shifts for a window of ARRAY_DIM cycles starting r cycles in,
  // giving the diagonal skew the array expects.
  always_comb begin
    fifo_shift = '0;
    if (state == S_COMPUTE) begin
      for (int r = 0; r < ARRAY_DIM; r++) begin
        fifo_shift[r] = (int'(comp_cnt) >= r) && (int'(comp_cnt) < r + ARRAY_DIM);
      end
    end
  end

endmodule

// File: tb/tb_systolic_array_load_sequencer.sv
// Bench for systolic_array_load_sequencer: directed vector table, corner-case sequences
// and random stimulus checked against a phase/position reference model.
module tb_systolic_array_load_sequencer;
  localparam int N  = 4;
  localparam int RW = $clog2(N);
  localparam int CL = 3*N-2;

  logic          clk = 1'b0;
  logic          rst, start, load_valid;
  logic          ready, load_ready, weight_load, input_load;
  logic [RW-1:0] load_row, row_out;
  logic          mac_start, mac_count, out_valid, done;
  logic [N-1:0]  fifo_shift;
  logic [RW:0]   iteration;

  systolic_array_load_sequencer #(.ARRAY_DIM(N)) dut (
    .CLK(clk), .RST(rst), .start(start), .ready(ready),
    .load_valid(load_valid), .load_ready(load_ready),
    .weight_load(weight_load), .input_load(input_load), .load_row(load_row),
    .mac_start(mac_start), .mac_count(mac_count), .fifo_shift(fifo_shift),
    .out_valid(out_valid), .row_out(row_out), .iteration(iteration), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          ready, load_ready, wl, il;
    logic [RW-1:0] row;
    logic          ms, mc;
    logic [N-1:0]  fs;
    logic          ov;
    logic [RW-1:0] ro;
    logic          done;
    logic [RW:0]   iter;
  } outs_t;

  typedef struct packed {
    logic  r, s, lv;
    outs_t e;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic last_done;
  vec_t tab[$];

  // Reference model: op in flight, beats taken so far, cycles since compute began.
  bit m_busy  = 0;
  int m_beats = 0;
  int m_k     = 0;
  int m_iter  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic outs_t model_outs(input logic lv);
    outs_t e;
    e = '0;
    e.iter = (RW+1)'(m_iter);
    if (!m_busy) begin
      e.ready = 1'b1;
    end else if (m_beats < 2*N) begin
      e.load_ready = 1'b1;
      if (lv) begin
        if (m_beats < N) begin
          e.wl = 1'b1; e.row = RW'(m_beats);
        end else begin
          e.il = 1'b1; e.row = RW'(m_beats - N);
        end
      end
    end else if (m_k < CL) begin
      e.mc = 1'b1;
      e.ms = (m_k == 0);
      for (int r = 0; r < N; r++) e.fs[r] = (m_k >= r) && (m_k < r + N);
    end else begin
      e.ov   = 1'b1;
      e.ro   = RW'(m_k - CL);
      e.done = (m_k - CL == N-1);
    end
    return e;
  endfunction

  task automatic model_step(input logic r, input logic s, input logic lv);
    if (r) begin
      m_busy = 0; m_beats = 0; m_k = 0; m_iter = 0;
    end else if (!m_busy) begin
      if (s) begin
        m_busy = 1; m_beats = 0; m_k = 0; m_iter = (m_iter + 1) % (1 << (RW+1));
      end
    end else if (m_beats < 2*N) begin
      if (lv) m_beats++;
    end else if (m_k == CL + N - 1) begin
      m_busy = 0;
    end else begin
      m_k++;
    end
  endtask

  // One clock cycle: drive, check mid-cycle, advance model after the edge.
  task automatic cycle(input logic r, input logic s, input logic lv,
                       input logic use_tab, input outs_t tab_e);
    outs_t e;
    rst = r; start = s; load_valid = lv;
    @(negedge clk);
    e = use_tab ? tab_e : model_outs(lv);
    last_done = done;
    chk("ready",       int'(ready),       int'(e.ready));
    chk("load_ready",  int'(load_ready),  int'(e.load_ready));
    chk("weight_load", int'(weight_load), int'(e.wl));
    chk("input_load",  int'(input_load),  int'(e.il));
    chk("load_row",    int'(load_row),    int'(e.row));
    chk("mac_start",   int'(mac_start),   int'(e.ms));
    chk("mac_count",   int'(mac_count),   int'(e.mc));
    chk("fifo_shift",  int'(fifo_shift),  int'(e.fs));
    chk("out_valid",   int'(out_valid),   int'(e.ov));
    chk("row_out",     int'(row_out),     int'(e.ro));
    chk("done",        int'(done),        int'(e.done));
    chk("iteration",   int'(iteration),   int'(e.iter));
    @(posedge clk);
    #1;
    model_step(r, s, lv);
  endtask

  task automatic run_op(input bit gap, input logic noise, output int lat);
    int   got;
    logic lv;
    got = 0;
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    for (int j = 0; j < 64 && got < 2*N; j++) begin
      lv = gap ? logic'(j % 2 == 0) : 1'b1;
      cycle(1'b0, noise, lv, 1'b0, '0);
      if (lv) got++;
    end
    lat = 0;
    do begin
      cycle(1'b0, noise, noise, 1'b0, '0);
      lat++;
    end while (!last_done && lat < 40);
    chk("done_latency", lat, CL + N);
  endtask

  function automatic vec_t mkv(input logic r, input logic s, input logic lv, input outs_t e);
    vec_t v;
    v.r = r; v.s = s; v.lv = lv; v.e = e;
    return v;
  endfunction

  initial begin
    outs_t e;
    int    lat;
    int    wrap_exp[8] = '{1, 2, 3, 4, 5, 6, 7, 0};

    // Nominal-run vector table, written directly from the expected cycle-by-cycle behaviour.
    e = '0; e.ready = 1'b1;
    tab.push_back(mkv(1'b0, 1'b0, 1'b0, e));
    tab.push_back(mkv(1'b0, 1'b1, 1'b0, e));
    for (int i = 0; i < N; i++) begin
      e = '0; e.load_ready = 1'b1; e.wl = 1'b1; e.row = RW'(i); e.iter = 1;
      tab.push_back(mkv(1'b0, 1'b0, 1'b1, e));
    end
    for (int i = 0; i < N; i++) begin
      e = '0; e.load_ready = 1'b1; e.il = 1'b1; e.row = RW'(i); e.iter = 1;
      tab.push_back(mkv(1'b0, 1'b0, 1'b1, e));
    end
    for (int k = 0; k < CL; k++) begin
      e = '0; e.mc = 1'b1; e.ms = (k == 0); e.iter = 1;
      for (int r = 0; r < N; r++) e.fs[r] = (k >= r) && (k <= r + N - 1);
      tab.push_back(mkv(1'b0, 1'b0, 1'b0, e));
    end
    for (int d = 0; d < N; d++) begin
      e = '0; e.ov = 1'b1; e.ro = RW'(d); e.done = (d == N-1); e.iter = 1;
      tab.push_back(mkv(1'b0, 1'b0, 1'b0, e));
    end
    e = '0; e.ready = 1'b1; e.iter = 1;
    tab.push_back(mkv(1'b0, 1'b0, 1'b0, e));

    rst = 1'b1; start = 1'b0; load_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_step(1'b1, 1'b0, 1'b0);

    foreach (tab[i]) cycle(tab[i].r, tab[i].s, tab[i].lv, 1'b1, tab[i].e);

    // Idle noise: load_valid held without start.
    repeat (6) cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);

    // Gapped loads, then busy start with load_valid noise during compute/drain.
    run_op(1'b1, 1'b0, lat);
    run_op(1'b0, 1'b1, lat);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("iter_after_busy_start", int'(iteration), 3);

    // Reset at compute cycle 5, then a clean nominal op.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    repeat (2*N) cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
    repeat (5) cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("midrst_iter", int'(iteration), 0);
    run_op(1'b0, 1'b0, lat);
    chk("after_rst_iter", int'(iteration), 1);

    // Iteration wrap across eight operations.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 8; i++) begin
      run_op(1'b0, 1'b0, lat);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
      chk("wrap_iter", int'(iteration), wrap_exp[i]);
    end

    // Random stimulus against the model.
    for (int i = 0; i < 1500; i++) begin
      cycle(logic'($urandom_range(0, 99) < 2), logic'($urandom_range(0, 9) < 3),
            logic'($urandom_range(0, 1)), 1'b0, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
